// File: rtl/dac_output_stage_if.sv
// SPI link from the DAC output stage to an external serial DAC.
// Master drives the clock, the chip select and the data; slave observes them.
// All three lines are registered by the master.
interface dac_output_stage_if;
   logic dac_sclk;
   logic dac_cs_n;
   logic dac_mosi;

   modport master (output dac_sclk, dac_cs_n, dac_mosi);
   modport slave  (input  dac_sclk, dac_cs_n, dac_mosi);
endinterface

// File: rtl/dac_output_stage.sv
// Decimates the generator stream, scales/offsets/saturates it, and shifts it to an SPI DAC.
// Latency: tick in cycle 0, cs_n falls in cycle 3, frame plus gap done at cycle 3+33*CLK_DIV.
// Backpressure: a tick arriving while busy is dropped and counted in overrun_cnt (saturating).
module dac_output_stage #(
   parameter int CLK_DIV  = 2,
   parameter int DAC_BITS = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [15:0]         sample_period,
   input  logic [31:0]         signal,
   input  logic [15:0]         amplitude,
   input  logic [15:0]         offset,
   output logic                sample_strobe,
   output logic                busy,
   output logic [15:0]         overrun_cnt,
   dac_output_stage_if.master  dac
);

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   state_t              state_q, state_d;
   logic [15:0]         cnt;
   logic [15:0]         period_last;
   logic                tick;
   logic                v1, v2;
   logic [15:0]         s16;
   logic [15:0]         scaled;
   logic [31:0]         prod;
   logic [16:0]         sum;
   logic [DAC_BITS-1:0] word;
   logic [7:0]          div_q, div_d;
   logic [3:0]          bit_q, bit_d;
   logic [DAC_BITS-1:0] sh_q, sh_d;
   logic                sclk_q, sclk_d;
   logic                cs_n_q, cs_n_d;
   logic                mosi_q, mosi_d;
   logic                unused_low_bits;

   // Only the upper half of the generator word reaches the DAC.
   assign unused_low_bits = ^signal[15:0];

   // A period of 0 behaves like 1: tick every enabled cycle.
   assign period_last   = (sample_period == 16'd0) ? 16'd0 : sample_period - 16'd1;
   assign tick          = enable && (cnt == period_last);
   assign busy          = v1 | v2 | (state_q != IDLE);
   assign sample_strobe = tick & ~busy;

   assign prod = 32'(s16) * 32'(amplitude);
   assign sum  = {1'b0, scaled} + {1'b0, offset};
   assign word = sum[16] ? {DAC_BITS{1'b1}} : sum[DAC_BITS-1:0];

   assign dac.dac_sclk = sclk_q;
   assign dac.dac_cs_n = cs_n_q;
   assign dac.dac_mosi = mosi_q;

   // Sample-rate counter; held at zero while disabled, wraps through 0xFFFF if overtaken.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)       cnt <= 16'd0;
      else if (!enable) cnt <= 16'd0;
      else if (tick)    cnt <= 16'd0;
      else              cnt <= cnt + 16'd1;
   end

   // Count ticks that arrive while the pipeline or SPI frame is still occupied.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         overrun_cnt <= 16'd0;
      else if (tick && busy && (overrun_cnt != 16'hFFFF))
         overrun_cnt <= overrun_cnt + 16'd1;
   end

   // Two-stage arithmetic pipeline: capture, then scale; offset/saturate feeds the shifter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v1     <= 1'b0;
         v2     <= 1'b0;
         s16    <= 16'd0;
         scaled <= 16'd0;
      end else begin
         v1 <= sample_strobe;
         v2 <= v1;
         if (sample_strobe) s16    <= signal[31:16];
         if (v1)            scaled <= prod[31:16];
      end
   end

   // SPI state and registered pin values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         div_q   <= 8'd0;
         bit_q   <= 4'd0;
         sh_q    <= '0;
         sclk_q  <= 1'b0;
         cs_n_q  <= 1'b1;
         mosi_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         sclk_q  <= sclk_d;
         cs_n_q  <= cs_n_d;
         mosi_q  <= mosi_d;
      end
   end

   // Next-state and next-pin logic: each bit is CLK_DIV cycles low then CLK_DIV high.
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      sclk_d  = sclk_q;
      cs_n_d  = cs_n_q;
      mosi_d  = mosi_q;
      case (state_q)
         IDLE: begin
            if (v2) begin
               state_d = SHIFT;
               sh_d    = word;
               bit_d   = 4'd15;
               div_d   = 8'd0;
               sclk_d  = 1'b0;
               cs_n_d  = 1'b0;
               mosi_d  = word[DAC_BITS-1];
            end
         end
         SHIFT: begin
            if (div_q == DIV_LAST) begin
               div_d = 8'd0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else if (bit_q == 4'd0) begin
                  state_d = GAP;
                  sclk_d  = 1'b0;
                  cs_n_d  = 1'b1;
                  mosi_d  = 1'b0;
               end else begin
                  bit_d  = bit_q - 4'd1;
                  sh_d   = {sh_q[DAC_BITS-2:0], 1'b0};
                  sclk_d = 1'b0;
                  mosi_d = sh_q[DAC_BITS-2];
               end
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         GAP: begin
            if (div_q == DIV_LAST) begin
               div_d   = 8'd0;
               state_d = IDLE;
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
